// File: rtl/tc_pl_spi_master_ctrl.sv
// SPI master engine (mode 0, MSB first) sequencing the PL bus TX/RX FIFO pair.
// Pops 9-bit words ([8] = last byte of transfer) from the TX FIFO, shifts each byte
// out on MOSI while capturing MISO, and pushes every received byte into the RX FIFO.
module tc_pl_spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       txbo_req,
    input  logic [8:0] txbo_data,
    input  logic       txb_empty,
    output logic [7:0] rxbi_data,
    output logic       rxbi_valid,
    input  logic       rxb_full,
    input  logic       rx_ovf_clr,
    output logic       rx_ovf,
    output logic       busy,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_DONE, S_HOLD, S_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t     state, state_nxt;
    logic [7:0] div_cnt;
    logic [3:0] half_cnt;
    logic [7:0] gap_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [7:0] rx_nxt;
    logic       last_f;
    logic       miso_m, miso_s;
    logic       samp_d;
    logic       div_last;
    logic       shift_end;
    logic       go;

    assign div_last  = (div_cnt == DIV_LAST);
    assign shift_end = (state == S_SHIFT) && div_last && (half_cnt == 4'hF);
    assign go        = enable && !txb_empty;

    // MISO reaches the capture register one cycle after the rising SCK edge so the
    // sampled bit has passed through the 2-flop synchroniser (keeps loopback exact).
    assign rx_nxt = samp_d ? {rx_sh[6:0], miso_s} : rx_sh;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and FIFO handshake strobes
    always_comb begin
        state_nxt  = state;
        txbo_req   = 1'b0;
        rxbi_valid = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (go) state_nxt = S_FETCH;
            S_FETCH: begin
                txbo_req  = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (shift_end) state_nxt = S_DONE;
            S_DONE: begin
                rxbi_valid = !rxb_full;
                // enable low here means it dropped mid-byte: close the transfer
                if (last_f || !enable) state_nxt = S_GAP;
                else if (go)           state_nxt = S_FETCH;
                else                   state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (go)           state_nxt = S_FETCH;
                else if (!enable) state_nxt = S_GAP;
            end
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift datapath, SCK divider and SPI pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_m    <= 1'b0;
            miso_s    <= 1'b0;
            samp_d    <= 1'b0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            last_f    <= 1'b0;
            div_cnt   <= 8'h00;
            half_cnt  <= 4'h0;
            rxbi_data <= 8'h00;
            spi_cs_n  <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            miso_m <= spi_miso;
            miso_s <= miso_m;
            // strobe on every rising SCK edge (end of an even half-period)
            samp_d <= (state == S_SHIFT) && div_last && !half_cnt[0];
            rx_sh  <= rx_nxt;
            case (state)
                S_LOAD: begin
                    tx_sh    <= txbo_data[7:0];
                    last_f   <= txbo_data[8];
                    rx_sh    <= 8'h00;
                    div_cnt  <= 8'h00;
                    half_cnt <= 4'h0;
                    spi_cs_n <= 1'b0;
                    spi_sck  <= 1'b0;
                    spi_mosi <= txbo_data[7];
                end
                S_SHIFT: begin
                    if (div_last) begin
                        div_cnt  <= 8'h00;
                        half_cnt <= half_cnt + 4'h1;
                        spi_sck  <= !half_cnt[0];
                        // falling edge: present the next bit unless the byte is complete
                        if (half_cnt[0] && half_cnt != 4'hF) begin
                            spi_mosi <= tx_sh[6];
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                        end
                        if (half_cnt == 4'hF) rxbi_data <= rx_nxt;
                    end else begin
                        div_cnt <= div_cnt + 8'h01;
                    end
                end
                default: ;
            endcase
            if (state_nxt == S_GAP) spi_cs_n <= 1'b1;
        end
    end

    // CS-high gap counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 gap_cnt <= 8'h00;
        else if (state == S_GAP) gap_cnt <= gap_cnt + 8'h01;
        else                     gap_cnt <= 8'h00;
    end

    // Sticky RX overflow flag; a new overflow beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            rx_ovf <= 1'b0;
        else if (state == S_DONE && rxb_full) rx_ovf <= 1'b1;
        else if (rx_ovf_clr)                rx_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_tc_pl_spi_master_ctrl.sv
// Directed bench for tc_pl_spi_master_ctrl with CLK_DIV=2, GAP_CYC=4 and MISO looped
// back from MOSI. A small TX FIFO model feeds the engine; a monitor counts strobes/edges.
module tb_tc_pl_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       txbo_req;
    logic [8:0] txbo_data;
    logic       txb_empty;
    logic [7:0] rxbi_data;
    logic       rxbi_valid;
    logic       rxb_full;
    logic       rx_ovf_clr;
    logic       rx_ovf;
    logic       busy;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;

    int n_cmp = 0;
    int n_err = 0;

    // monitor state
    int         cyc = 0;
    int         req_cnt = 0, rx_cnt = 0, sck_rise = 0, cs_rise = 0;
    int         req_cyc = 0, rx_cyc = 0;
    logic [7:0] rx_last = 8'h00;
    logic [7:0] mosi_sh = 8'h00;
    logic       sck_prev = 1'b0, cs_prev = 1'b1;

    logic [8:0] txq[$];

    assign spi_miso = spi_mosi;

    always #5 clk = ~clk;

    tc_pl_spi_master_ctrl #(.CLK_DIV(2), .GAP_CYC(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .txbo_req(txbo_req), .txbo_data(txbo_data), .txb_empty(txb_empty),
        .rxbi_data(rxbi_data), .rxbi_valid(rxbi_valid), .rxb_full(rxb_full),
        .rx_ovf_clr(rx_ovf_clr), .rx_ovf(rx_ovf), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    // TX FIFO model: dout valid the cycle after the read strobe
    always @(posedge clk) begin
        if (txbo_req && txq.size() > 0) begin
            txbo_data <= txq.pop_front();
            txb_empty <= (txq.size() == 0);
        end
    end

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (txbo_req) begin req_cnt = req_cnt + 1; req_cyc = cyc; end
        if (rxbi_valid) begin rx_cnt = rx_cnt + 1; rx_cyc = cyc; rx_last = rxbi_data; end
        if (spi_sck && !sck_prev) begin
            sck_rise = sck_rise + 1;
            mosi_sh  = {mosi_sh[6:0], spi_mosi};
        end
        if (spi_cs_n && !cs_prev) cs_rise = cs_rise + 1;
        sck_prev = spi_sck;
        cs_prev  = spi_cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] w);
        txq.push_back(w);
        txb_empty = 1'b0;
    endtask

    // sel: 0 = rx pulses, 1 = txbo_req pulses, 2 = sck rising edges
    task automatic wait_ge(input string tag, input int sel, input int target);
        int k = 0;
        int v;
        v = (sel == 0) ? rx_cnt : (sel == 1) ? req_cnt : sck_rise;
        while (v < target && k < 400) begin
            step(1);
            k++;
            v = (sel == 0) ? rx_cnt : (sel == 1) ? req_cnt : sck_rise;
        end
        check(tag, 32'(v >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 400) begin step(1); k++; end
        check(tag, 32'(busy), 32'd0);
    endtask

    int b_rx, b_req, b_cs, b_sck;

    initial begin
        rst = 1'b1; enable = 1'b0; txb_empty = 1'b1; txbo_data = 9'h000;
        rxb_full = 1'b0; rx_ovf_clr = 1'b0;
        step(3);
        check("rst_txbo_req", 32'(txbo_req), 0);
        check("rst_rxbi_valid", 32'(rxbi_valid), 0);
        check("rst_rxbi_data", 32'(rxbi_data), 0);
        check("rst_rx_ovf", 32'(rx_ovf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cs_n", 32'(spi_cs_n), 1);
        check("rst_sck", 32'(spi_sck), 0);
        check("rst_mosi", 32'(spi_mosi), 0);
        rst = 1'b0;
        step(2);

        // 1: single last-flagged byte, loopback
        enable = 1'b1;
        b_req = req_cnt; b_rx = rx_cnt;
        push(9'h1A5);
        wait_ge("t1_rx", 0, b_rx + 1);
        check("t1_req_cnt", 32'(req_cnt - b_req), 1);
        check("t1_latency", 32'(rx_cyc - req_cyc), 34);
        check("t1_rx_data", 32'(rx_last), 32'hA5);
        check("t1_mosi", 32'(mosi_sh), 32'hA5);
        step(4);
        check("t1_gap_cs", 32'(spi_cs_n), 1);
        check("t1_gap_busy", 32'(busy), 1);
        step(1);
        check("t1_idle", 32'(busy), 0);

        // 2: three back-to-back bytes in one CS window
        b_rx = rx_cnt; b_cs = cs_rise;
        push(9'h012); push(9'h034); push(9'h156);
        wait_ge("t2_rx", 0, b_rx + 3);
        check("t2_cs_held", 32'(cs_rise - b_cs), 0);
        check("t2_last_data", 32'(rx_last), 32'h56);
        wait_idle("t2_idle");
        check("t2_cs_released", 32'(cs_rise - b_cs), 1);

        // 3: FIFO runs dry mid-transfer -> HOLD, then resume without CS toggle
        b_rx = rx_cnt; b_cs = cs_rise; b_req = req_cnt;
        push(9'h055);
        wait_ge("t3_rx0", 0, b_rx + 1);
        check("t3_data0", 32'(rx_last), 32'h55);
        step(50);
        check("t3_hold_cs", 32'(spi_cs_n), 0);
        check("t3_hold_sck", 32'(spi_sck), 0);
        check("t3_hold_busy", 32'(busy), 1);
        check("t3_hold_req", 32'(req_cnt - b_req), 1);
        push(9'h1AA);
        wait_ge("t3_rx1", 0, b_rx + 2);
        check("t3_data1", 32'(rx_last), 32'hAA);
        check("t3_no_toggle", 32'(cs_rise - b_cs), 0);
        wait_idle("t3_idle");

        // 4: RX FIFO full -> dropped byte, sticky overflow, then clear
        b_rx = rx_cnt;
        rxb_full = 1'b1;
        push(9'h177);
        step(2);
        wait_idle("t4_idle");
        check("t4_no_push", 32'(rx_cnt - b_rx), 0);
        check("t4_ovf_set", 32'(rx_ovf), 1);
        rxb_full = 1'b0;
        rx_ovf_clr = 1'b1;
        step(1);
        rx_ovf_clr = 1'b0;
        check("t4_ovf_clr", 32'(rx_ovf), 0);

        // 5: reset in the 5th SCK period, then a fresh transfer
        b_rx = rx_cnt; b_sck = sck_rise;
        push(9'h1C3);
        wait_ge("t5_sck5", 2, b_sck + 5);
        rst = 1'b1;
        #1;
        check("t5_cs_n", 32'(spi_cs_n), 1);
        check("t5_sck", 32'(spi_sck), 0);
        check("t5_busy", 32'(busy), 0);
        step(3);
        rst = 1'b0;
        step(40);
        check("t5_no_push", 32'(rx_cnt - b_rx), 0);
        push(9'h13C);
        wait_ge("t5_rx", 0, b_rx + 1);
        check("t5_fresh_data", 32'(rx_last), 32'h3C);
        wait_idle("t5_idle");

        // 6: enable drops mid-SHIFT on a non-last byte
        b_rx = rx_cnt; b_req = req_cnt;
        push(9'h0F0); push(9'h1FF);
        wait_ge("t6_req", 1, b_req + 1);
        step(10);
        enable = 1'b0;
        wait_ge("t6_rx", 0, b_rx + 1);
        check("t6_data", 32'(rx_last), 32'hF0);
        wait_idle("t6_idle");
        step(20);
        check("t6_req_cnt", 32'(req_cnt - b_req), 1);
        check("t6_rx_cnt", 32'(rx_cnt - b_rx), 1);
        check("t6_cs_idle", 32'(spi_cs_n), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
